// File: rtl/heater_sequencer_if.sv
// Host/heater-side signal bundle for heater_sequencer.
// master drives the requests and heater error flags; slave is the sequencer itself.
interface heater_sequencer_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
);
  logic [N-1:0]     target_enable;
  logic [N-1:0]     fault_clear;
  logic [N-1:0]     heater_error;
  logic [N-1:0]     heater_enable;
  logic [N-1:0]     heater_err_clear;
  logic [N-1:0]     fault;
  logic [CNT_W-1:0] error_count;
  logic             busy;

  modport master (
    output target_enable, fault_clear, heater_error,
    input  heater_enable, heater_err_clear, fault, error_count, busy
  );

  modport slave (
    input  target_enable, fault_clear, heater_error,
    output heater_enable, heater_err_clear, fault, error_count, busy
  );
endinterface

// File: rtl/heater_sequencer.sv
// Heater array sequencer: rate-limited enable ramp toward the requested mask,
// with immediate per-heater shutdown, err_clear pulsing and fault latching on errors.
module heater_sequencer #(
  parameter int N           = 32,
  parameter int STEP_CYCLES = 4096,
  parameter int CLR_CYCLES  = 4,
  parameter int CNT_W       = 16
) (
  input logic             clk,
  input logic             reset,
  heater_sequencer_if.slave bus
);

  localparam int TW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int CCW = $clog2(CLR_CYCLES + 1);
  localparam int PW  = $clog2(N + 1);
  localparam int SW  = CNT_W + PW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [N-1:0]   err_q;
  logic [N-1:0]   eff;
  logic [N-1:0]   new_fault;
  logic [N-1:0]   up_sel;
  logic [N-1:0]   dn_sel;
  logic [N-1:0]   ramp_en;
  logic [N-1:0]   en_next;
  logic [N-1:0]   fault_next;
  logic [N-1:0]   clr_out_next;
  logic [TW-1:0]  timer;
  logic [TW-1:0]  timer_next;
  logic [1:0]     state;
  logic [CCW-1:0] clr_cnt [N];
  logic [PW-1:0]  fault_pop;
  logic [SW-1:0]  count_sum;

  always_comb begin
    eff       = bus.target_enable & ~bus.fault;
    new_fault = err_q & bus.heater_enable & ~bus.fault;

    if (timer != '0)                    state = ST_WAIT;
    else if (bus.heater_enable != eff)  state = ST_STEP;
    else                                state = ST_IDLE;

    // Ramp-up prefers the lowest missing bit; ramp-down drops the highest extra bit.
    up_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eff[i] && !bus.heater_enable[i]) begin
        up_sel    = '0;
        up_sel[i] = 1'b1;
      end
    end
    dn_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (!eff[i] && bus.heater_enable[i]) begin
        dn_sel    = '0;
        dn_sel[i] = 1'b1;
      end
    end

    ramp_en    = bus.heater_enable;
    timer_next = timer;
    case (state)
      ST_WAIT: timer_next = timer - TW'(1);
      ST_STEP: begin
        ramp_en    = (up_sel != '0) ? (bus.heater_enable | up_sel)
                                    : (bus.heater_enable & ~dn_sel);
        timer_next = TW'(STEP_CYCLES - 1);
      end
      ST_IDLE: ;
      default: ;
    endcase

    // A fault overrides any ramp decision on the same bit but leaves the timer alone.
    en_next    = ramp_en & ~new_fault;
    fault_next = (bus.fault & ~bus.fault_clear) | new_fault;

    fault_pop = '0;
    for (int i = 0; i < N; i++) begin
      fault_pop = fault_pop + PW'(new_fault[i]);
    end
    count_sum = SW'(bus.error_count) + SW'(fault_pop);

    clr_out_next = '0;
    for (int i = 0; i < N; i++) begin
      clr_out_next[i] = new_fault[i] || (clr_cnt[i] > CCW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q                <= '0;
      timer                <= '0;
      bus.heater_enable    <= '0;
      bus.heater_err_clear <= '0;
      bus.fault            <= '0;
      bus.error_count      <= '0;
      bus.busy             <= 1'b0;
      for (int i = 0; i < N; i++) clr_cnt[i] <= '0;
    end else begin
      err_q                <= bus.heater_error;
      timer                <= timer_next;
      bus.heater_enable    <= en_next;
      bus.heater_err_clear <= clr_out_next;
      bus.fault            <= fault_next;
      bus.busy             <= (en_next != (bus.target_enable & ~fault_next));
      bus.error_count      <= (count_sum > SW'(CNT_MAX)) ? CNT_MAX : count_sum[CNT_W-1:0];
      for (int i = 0; i < N; i++) begin
        if (new_fault[i])            clr_cnt[i] <= CCW'(CLR_CYCLES);
        else if (clr_cnt[i] != '0)   clr_cnt[i] <= clr_cnt[i] - CCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_heater_sequencer.sv
// Scoreboard bench for heater_sequencer: a rule-level model predicts every cycle's
// outputs into a queue that a negedge monitor drains against the DUT.
module tb_heater_sequencer;

  localparam int N     = 8;
  localparam int STEP  = 8;
  localparam int CLR   = 4;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [N-1:0]     en;
    logic [N-1:0]     clr;
    logic [N-1:0]     flt;
    logic [CNT_W-1:0] cnt;
    logic             busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];

  bit m_en[N];
  bit m_flt[N];
  bit m_errq[N];
  int m_clr[N];
  int m_timer;
  int m_count;

  heater_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

  heater_sequencer #(
    .N(N), .STEP_CYCLES(STEP), .CLR_CYCLES(CLR), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Applies the behavioural rules for one clock edge and queues the predicted outputs.
  task automatic modelStep(input logic [N-1:0] t, input logic [N-1:0] fc, input logic [N-1:0] he, input bit r);
    bit   nf[N];
    bit   en_n[N];
    bit   flt_n[N];
    int   up, dn, added;
    exp_t e;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_en[i] = 0; m_flt[i] = 0; m_errq[i] = 0; m_clr[i] = 0;
      end
      m_timer = 0;
      m_count = 0;
    end else begin
      for (int i = 0; i < N; i++) nf[i] = m_errq[i] && m_en[i] && !m_flt[i];
      en_n = m_en;
      if (m_timer > 0) begin
        m_timer--;
      end else begin
        up = -1;
        dn = -1;
        for (int i = 0; i < N; i++) begin
          if (t[i] && !m_flt[i] && !m_en[i] && up < 0) up = i;
          if (!(t[i] && !m_flt[i]) && m_en[i]) dn = i;
        end
        if (up >= 0) begin
          en_n[up] = 1; m_timer = STEP - 1;
        end else if (dn >= 0) begin
          en_n[dn] = 0; m_timer = STEP - 1;
        end
      end
      added = 0;
      for (int i = 0; i < N; i++) begin
        if (nf[i]) begin
          en_n[i] = 0; flt_n[i] = 1; m_clr[i] = CLR; added++;
        end else begin
          flt_n[i] = m_flt[i] && !fc[i];
          if (m_clr[i] > 0) m_clr[i]--;
        end
      end
      m_count = (m_count + added > MAXC) ? MAXC : m_count + added;
      m_en  = en_n;
      m_flt = flt_n;
      for (int i = 0; i < N; i++) m_errq[i] = he[i];
    end
    e = '0;
    for (int i = 0; i < N; i++) begin
      e.en[i]  = m_en[i];
      e.flt[i] = m_flt[i];
      e.clr[i] = (m_clr[i] > 0);
      if (!r && (m_en[i] != (t[i] && !m_flt[i]))) e.busy = 1'b1;
    end
    e.cnt = CNT_W'(m_count);
    expq.push_back(e);
  endtask

  task automatic applyStimulus(input logic [N-1:0] t, input logic [N-1:0] fc, input logic [N-1:0] he,
                               input bit r, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus.target_enable = t;
      bus.fault_clear   = fc;
      bus.heater_error  = he;
      reset             = r;
      @(posedge clk);
      modelStep(t, fc, he, r);
      #1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("sb_heater_enable", 32'(bus.heater_enable), 32'(e.en));
        checkOutput("sb_heater_err_clear", 32'(bus.heater_err_clear), 32'(e.clr));
        checkOutput("sb_fault", 32'(bus.fault), 32'(e.flt));
        checkOutput("sb_error_count", 32'(bus.error_count), 32'(e.cnt));
        checkOutput("sb_busy", 32'(bus.busy), 32'(e.busy));
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] tgt;
    logic [N-1:0] fc;
    logic [N-1:0] he;
    bit           r;
    applyStimulus('0, '0, '0, 1'b1, 3);
    checkOutput("reset_enable", 32'(bus.heater_enable), 32'h00);
    checkOutput("reset_count", 32'(bus.error_count), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);

    // Ramp up to 0xFF: one bit every STEP cycles from the first edge out of reset.
    applyStimulus(8'hFF, '0, '0, 1'b0, 1);
    checkOutput("ramp_first_step", 32'(bus.heater_enable), 32'h01);
    checkOutput("ramp_busy", 32'(bus.busy), 32'h1);
    applyStimulus(8'hFF, '0, '0, 1'b0, 8);
    checkOutput("ramp_second_step", 32'(bus.heater_enable), 32'h03);
    applyStimulus(8'hFF, '0, '0, 1'b0, 48);
    checkOutput("ramp_full", 32'(bus.heater_enable), 32'hFF);
    checkOutput("ramp_done_busy", 32'(bus.busy), 32'h0);
    checkOutput("ramp_no_clr", 32'(bus.heater_err_clear), 32'h00);

    applyStimulus(8'h0F, '0, '0, 1'b0, 8);
    checkOutput("rampdown_first", 32'(bus.heater_enable), 32'h7F);
    applyStimulus(8'h0F, '0, '0, 1'b0, 24);
    checkOutput("rampdown_done", 32'(bus.heater_enable), 32'h0F);
    checkOutput("rampdown_busy", 32'(bus.busy), 32'h0);
    applyStimulus(8'hFF, '0, '0, 1'b0, 40);

    // Single fault on heater 3, then release it.
    applyStimulus(8'hFF, '0, 8'h08, 1'b0, 1);
    applyStimulus(8'hFF, '0, '0, 1'b0, 1);
    checkOutput("fault3_enable", 32'(bus.heater_enable), 32'hF7);
    checkOutput("fault3_fault", 32'(bus.fault), 32'h08);
    checkOutput("fault3_count", 32'(bus.error_count), 32'h1);
    applyStimulus(8'hFF, '0, '0, 1'b0, 3);
    checkOutput("fault3_clr_last", 32'(bus.heater_err_clear), 32'h08);
    applyStimulus(8'hFF, '0, '0, 1'b0, 1);
    checkOutput("fault3_clr_end", 32'(bus.heater_err_clear), 32'h00);
    applyStimulus(8'hFF, 8'h08, '0, 1'b0, 1);
    checkOutput("fault3_released", 32'(bus.fault), 32'h00);
    applyStimulus(8'hFF, '0, '0, 1'b0, 1);
    checkOutput("fault3_reenabled", 32'(bus.heater_enable), 32'hFF);

    // Two simultaneous faults, then an error on a disabled heater.
    applyStimulus(8'hFF, '0, 8'h05, 1'b0, 1);
    applyStimulus(8'hFF, '0, '0, 1'b0, 1);
    checkOutput("dual_fault", 32'(bus.fault), 32'h05);
    checkOutput("dual_count", 32'(bus.error_count), 32'h3);
    applyStimulus(8'h7F, 8'h05, '0, 1'b0, 1);
    applyStimulus(8'h7F, '0, '0, 1'b0, 40);
    applyStimulus(8'h7F, '0, 8'h80, 1'b0, 1);
    applyStimulus(8'h7F, '0, '0, 1'b0, 2);
    checkOutput("disabled_err_fault", 32'(bus.fault), 32'h00);
    checkOutput("disabled_err_count", 32'(bus.error_count), 32'h3);

    // Error and release on heater 2 in the same cycle: error wins.
    applyStimulus(8'h7F, '0, 8'h04, 1'b0, 1);
    applyStimulus(8'h7F, 8'h04, '0, 1'b0, 1);
    checkOutput("collide_fault", 32'(bus.fault), 32'h04);
    checkOutput("collide_count", 32'(bus.error_count), 32'h4);
    applyStimulus(8'h7F, 8'h04, '0, 1'b0, 1);
    applyStimulus(8'h7F, '0, '0, 1'b0, 20);

    // Drive the counter into saturation.
    applyStimulus(8'h7F, '0, 8'h7F, 1'b0, 1);
    applyStimulus(8'h7F, '0, '0, 1'b0, 1);
    checkOutput("sat_partial", 32'(bus.error_count), 32'd11);
    applyStimulus(8'h7F, 8'h7F, '0, 1'b0, 1);
    applyStimulus(8'h7F, '0, '0, 1'b0, 60);
    applyStimulus(8'h7F, '0, 8'h7F, 1'b0, 1);
    applyStimulus(8'h7F, '0, '0, 1'b0, 1);
    checkOutput("sat_hold", 32'(bus.error_count), 32'd15);

    // Fault on the bit just ramped in; the ramp keeps its cadence.
    applyStimulus(8'h7F, 8'h7F, '0, 1'b0, 1);
    applyStimulus(8'h7F, '0, '0, 1'b0, 1);
    applyStimulus(8'h7F, '0, 8'h01, 1'b0, 1);
    applyStimulus(8'h7F, '0, '0, 1'b0, 1);
    checkOutput("rampin_fault_en", 32'(bus.heater_enable), 32'h00);
    checkOutput("rampin_fault_flt", 32'(bus.fault), 32'h01);
    applyStimulus(8'h7F, '0, '0, 1'b0, 6);
    checkOutput("rampin_next_step", 32'(bus.heater_enable), 32'h02);

    // Reset while ramping with an err_clear pulse in flight.
    applyStimulus(8'h7F, '0, 8'h02, 1'b0, 1);
    applyStimulus(8'h7F, '0, '0, 1'b0, 1);
    checkOutput("pre_reset_clr", 32'(bus.heater_err_clear), 32'h02);
    applyStimulus(8'h7F, '0, '0, 1'b1, 1);
    checkOutput("midreset_clr", 32'(bus.heater_err_clear), 32'h00);
    checkOutput("midreset_fault", 32'(bus.fault), 32'h00);
    applyStimulus(8'h0F, '0, '0, 1'b0, 1);
    checkOutput("post_reset_step", 32'(bus.heater_enable), 32'h01);
    applyStimulus(8'h0F, '0, '0, 1'b0, 24);
    checkOutput("post_reset_done", 32'(bus.heater_enable), 32'h0F);

    // Randomized traffic against the scoreboard.
    tgt = 8'hFF;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) tgt = N'($urandom);
      he = ($urandom_range(0, 5) == 0) ? N'($urandom) & N'($urandom) : '0;
      fc = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      r  = ($urandom_range(0, 299) == 0);
      applyStimulus(tgt, fc, he, r, 1);
    end

    @(negedge clk);
    #1;
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
